// File: rtl/board_store.sv
// board_store: 64-square chess board register file.
// Takes single-square writes from the game logic and exports the packed board.
// Provides a registered read port for the renderer.
// Runs a 64-cycle sequenced reload of the start position on new_game.
// Optional feature macro: BOARD_CAPTURE_STATS_EN adds capture counters and
// king-capture game-over. When game_over is set, further writes are blocked.
module board_store (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [3:0]   wr_piece,
  input  logic         new_game,
  input  logic [5:0]   rd_addr,
  output logic [3:0]   rd_piece,
  output logic [255:0] board_flat,
  output logic         busy,
  output logic [9:0]   ply_count,
  output logic [4:0]   white_lost,
  output logic [4:0]   black_lost,
  output logic         game_over,
  output logic         winner
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Start-position contents of one square; row 0 is black's back rank.
  function automatic logic [3:0] start_piece(input logic [5:0] addr);
    logic [2:0] kind;
    case (addr[2:0])
      3'd0, 3'd7: kind = 3'd4;  // rook
      3'd1, 3'd6: kind = 3'd3;  // knight
      3'd2, 3'd5: kind = 3'd2;  // bishop
      3'd3:       kind = 3'd5;  // queen
      default:    kind = 3'd6;  // king
    endcase
    case (addr[5:3])
      3'd0:    start_piece = {1'b1, kind};
      3'd1:    start_piece = 4'h9;
      3'd6:    start_piece = 4'h1;
      3'd7:    start_piece = {1'b0, kind};
      default: start_piece = 4'h0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  load_addr_q, load_addr_d;
  logic [3:0]  board_q [64];
  logic [3:0]  board_d [64];
  logic [3:0]  rd_piece_q, rd_piece_d;
  logic [9:0]  ply_q, ply_d;
  logic        wr_blocked;
  logic        wr_accept;

`ifdef BOARD_CAPTURE_STATS_EN
  logic [4:0]  white_lost_q, white_lost_d;
  logic [4:0]  black_lost_q, black_lost_d;
  logic        game_over_q, game_over_d;
  logic        winner_q, winner_d;
  logic [3:0]  old_piece;
  logic        is_capture;

  assign wr_blocked = game_over_q;
  assign old_piece  = board_q[wr_addr];
  // A capture needs two non-empty pieces of opposite colour on the same square.
  assign is_capture = (old_piece[2:0] != 3'd0) && (wr_piece[2:0] != 3'd0) &&
                      (old_piece[3] != wr_piece[3]);
`else
  assign wr_blocked = 1'b0;
`endif

  // Writes from the game logic only land in IDLE; new_game always wins.
  assign wr_accept = (state_q == ST_IDLE) && wr_en && !new_game && !wr_blocked;

  // Next-state: reload sequencing, square writes, ply and capture bookkeeping.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    ply_d       = ply_q;
    for (int i = 0; i < 64; i++) begin
      board_d[i] = board_q[i];
    end
`ifdef BOARD_CAPTURE_STATS_EN
    white_lost_d = white_lost_q;
    black_lost_d = black_lost_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
`endif

    if (new_game) begin
      // Start (or restart) the reload from square 0 and clear game statistics.
      state_d     = ST_LOAD;
      load_addr_d = 6'd0;
      ply_d       = 10'd0;
`ifdef BOARD_CAPTURE_STATS_EN
      white_lost_d = 5'd0;
      black_lost_d = 5'd0;
      game_over_d  = 1'b0;
      winner_d     = 1'b0;
`endif
    end else if (state_q == ST_LOAD) begin
      board_d[load_addr_q] = start_piece(load_addr_q);
      load_addr_d          = load_addr_q + 6'd1;
      if (load_addr_q == 6'd63) begin
        state_d = ST_IDLE;
      end
    end else if (wr_accept) begin
      board_d[wr_addr] = wr_piece;
      // An erase write closes a move; the count saturates rather than wraps.
      if ((wr_piece[2:0] == 3'd0) && (ply_q != 10'd1023)) begin
        ply_d = ply_q + 10'd1;
      end
`ifdef BOARD_CAPTURE_STATS_EN
      if (is_capture) begin
        if (old_piece[3]) begin
          black_lost_d = black_lost_q + 5'd1;
        end else begin
          white_lost_d = white_lost_q + 5'd1;
        end
        if (old_piece[2:0] == 3'd6) begin
          game_over_d = 1'b1;
          winner_d    = wr_piece[3];
        end
      end
`endif
    end
  end

  // Display read port samples the registered board every cycle.
  always_comb begin
    rd_piece_d = board_q[rd_addr];
  end

  // Control and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_addr_q <= 6'd0;
      ply_q       <= 10'd0;
      rd_piece_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      ply_q       <= ply_d;
      rd_piece_q  <= rd_piece_d;
    end
  end

  // Board squares reset straight to the start position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        board_q[i] <= start_piece(6'(i));
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        board_q[i] <= board_d[i];
      end
    end
  end

`ifdef BOARD_CAPTURE_STATS_EN
  // Capture statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      white_lost_q <= 5'd0;
      black_lost_q <= 5'd0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      white_lost_q <= white_lost_d;
      black_lost_q <= black_lost_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign white_lost = white_lost_q;
  assign black_lost = black_lost_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
`else
  assign white_lost = 5'd0;
  assign black_lost = 5'd0;
  assign game_over  = 1'b0;
  assign winner     = 1'b0;
`endif

  // Pack the squares: square i occupies bits [4i+3:4i].
  for (genvar gi = 0; gi < 64; gi++) begin : g_flat
    assign board_flat[4*gi +: 4] = board_q[gi];
  end

  assign rd_piece  = rd_piece_q;
  assign busy      = (state_q == ST_LOAD);
  assign ply_count = ply_q;

endmodule
